// File: rtl/text_pkg.sv
// Shared definitions for the 7-bit ASCII text link.
//   CW_W / DATA_W   : codeword and character widths
//   DATA_POS        : codeword position (1-based) of each data bit d0..d6
//   hamming_enc     : character -> Hamming(11,7) codeword (even parity)
//   hamming_syndrome: codeword -> XOR of the indices of all set positions
//   hamming_extract : codeword -> character (reads the data positions)
//   pos_mask        : 1-based position -> one-hot flip mask (0 outside 1..11)
// Codeword vectors are packed so that bit [p-1] holds position p.
package text_pkg;

  localparam int CW_W   = 11;
  localparam int DATA_W = 7;

  // Entry i is the position of data bit di.
  localparam logic [DATA_W-1:0][3:0] DATA_POS =
    {4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3};

  function automatic logic [CW_W-1:0] pos_mask(input logic [3:0] pos);
    logic [CW_W-1:0] m;
    m = '0;
    if (pos >= 4'd1 && pos <= 4'(CW_W)) m[pos - 4'd1] = 1'b1;
    return m;
  endfunction

  function automatic logic [CW_W-1:0] hamming_enc(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    logic            p;
    cw = '0;
    for (int i = 0; i < DATA_W; i++) cw[DATA_POS[i] - 4'd1] = d[i];
    // Parity slots are still zero while their own parity is summed, so
    // including them in the XOR does not disturb the result.
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= CW_W; pos++) begin
        if (pos[k]) p = p ^ cw[pos-1];
      end
      cw[(1 << k) - 1] = p;
    end
    return cw;
  endfunction

  function automatic logic [3:0] hamming_syndrome(input logic [CW_W-1:0] cw);
    logic [3:0] s;
    s = 4'd0;
    for (int pos = 1; pos <= CW_W; pos++) begin
      if (cw[pos-1]) s = s ^ 4'(pos);
    end
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] hamming_extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i++) d[i] = cw[DATA_POS[i] - 4'd1];
    return d;
  endfunction

endpackage

// File: rtl/text_channel.sv
// Noisy channel model: registers the codeword with at most one bit flipped.
// A 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every clock out of reset;
// its low nibble picks the position to flip (1..11), other values flip nothing.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   cw_in  in   11-bit codeword from the encoder stage
//   cw_out out  11-bit registered channel word
module text_channel
  import text_pkg::*;
#(
  parameter bit          ERR_EN    = 1'b1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CW_W-1:0] cw_in,
  output logic [CW_W-1:0] cw_out
);

  logic [15:0]     lfsr_q, lfsr_d;
  logic [CW_W-1:0] err_mask;
  logic [CW_W-1:0] ch_q, ch_d;

  always_comb begin
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    err_mask = ERR_EN ? pos_mask(lfsr_q[3:0]) : '0;
    ch_d     = cw_in ^ err_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
      ch_q   <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      ch_q   <= ch_d;
    end
  end

  assign cw_out = ch_q;

endmodule

// File: rtl/text_comm_top.sv
// 7-bit ASCII text link: encoder -> noisy channel -> syndrome decoder.
// Three register stages, one character per clock, no handshake; data_out
// updates on the 3rd rising edge counting the edge that sampled data_in.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   data_in  in   7-bit transmit character
//   data_out out  7-bit received, corrected character
module text_comm_top
  import text_pkg::*;
#(
  parameter bit          ERR_EN    = 1'b1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [CW_W-1:0]   cw_q, cw_d;
  logic [CW_W-1:0]   ch_q;
  logic [3:0]        syndrome;
  logic [CW_W-1:0]   corrected;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  always_comb begin
    cw_d = hamming_enc(data_in);
  end

  text_channel #(
    .ERR_EN    (ERR_EN),
    .LFSR_SEED (LFSR_SEED)
  ) u_channel (
    .clk    (clk),
    .reset  (reset),
    .cw_in  (cw_q),
    .cw_out (ch_q)
  );

  // Syndromes 0 and 12..15 give an all-zero mask, so the word passes as-is.
  always_comb begin
    syndrome   = hamming_syndrome(ch_q);
    corrected  = ch_q ^ pos_mask(syndrome);
    data_out_d = hamming_extract(corrected);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cw_q       <= '0;
      data_out_q <= '0;
    end else begin
      cw_q       <= cw_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_text_comm_top.sv
module tb_text_comm_top;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk;
  logic       reset;
  logic [6:0] data_in;
  logic [6:0] data_out;
  logic [6:0] data_out_clean;

  int n_compared;
  int n_mismatched;

  // Reference model state: history of sampled characters since reset,
  // the codeword waiting to enter the channel, and the channel LFSR.
  logic [6:0]  hist[$];
  logic [10:0] cw_m;
  logic [15:0] lfsr_m;
  logic [11:0] seen_pos;

  text_comm_top #(.ERR_EN(1'b1), .LFSR_SEED(SEED)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  text_comm_top #(.ERR_EN(1'b0), .LFSR_SEED(SEED)) dut_clean (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out_clean)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data fills the non-power-of-two positions in order; each parity bit at
  // 2^k is the XOR of all other positions having bit k set.
  function automatic logic [11:1] ref_enc(input logic [6:0] d);
    logic [11:1] w;
    int j;
    w = '0;
    j = 0;
    for (int p = 1; p <= 11; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = d[j];
        j++;
      end
    end
    for (int p = 1; p <= 11; p++) begin
      if ((p & (p - 1)) == 0) begin
        for (int q = 1; q <= 11; q++) begin
          if (q != p && (q & p) != 0) w[p] = w[p] ^ w[q];
        end
      end
    end
    return w;
  endfunction

  function automatic int ref_err_pos(input logic [15:0] l);
    int e;
    e = int'(l[3:0]);
    return (e >= 1 && e <= 11) ? e : 0;
  endfunction

  function automatic logic [11:1] ref_mask(input logic [15:0] l);
    logic [11:1] w;
    int e;
    w = '0;
    e = ref_err_pos(l);
    if (e != 0) w[e] = 1'b1;
    return w;
  endfunction

  function automatic logic [15:0] ref_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic modelReset();
    hist.delete();
    cw_m   = '0;
    lfsr_m = SEED;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock with reset released: drive, clock, advance model, compare.
  task automatic applyStimulus(input logic [6:0] din);
    logic [10:0] exp_ch;
    logic [10:0] exp_ch_clean;
    logic [6:0]  exp_out;
    int          exp_syn;
    data_in = din;
    @(posedge clk);
    #1;
    exp_ch       = cw_m ^ ref_mask(lfsr_m);
    exp_ch_clean = cw_m;
    exp_syn      = ref_err_pos(lfsr_m);
    cw_m         = ref_enc(din);
    lfsr_m       = ref_step(lfsr_m);
    hist.push_back(din);
    if (hist.size() > 3) void'(hist.pop_front());
    exp_out = (hist.size() == 3) ? hist[0] : 7'h00;
    checkOutput("data_out", 16'(data_out), 16'(exp_out));
    checkOutput("data_out_clean", 16'(data_out_clean), 16'(exp_out));
    checkOutput("ch_q", 16'(dut.ch_q), 16'(exp_ch));
    checkOutput("ch_q_clean", 16'(dut_clean.ch_q), 16'(exp_ch_clean));
    checkOutput("syndrome", 16'(dut.syndrome), 16'(exp_syn));
    if (dut.syndrome >= 4'd1 && dut.syndrome <= 4'd11) seen_pos[dut.syndrome] = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [6:0] din;
    int         cycles;
    logic [6:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [10:0] fcw;
    n_compared   = 0;
    n_mismatched = 0;
    seen_pos     = '0;
    data_in      = 7'h00;
    reset        = 1'b1;
    modelReset();

    vecs[0] = '{"hold_05", 7'h05, 5000, 7'h05};
    vecs[1] = '{"hold_41", 7'h41, 8,    7'h41};
    vecs[2] = '{"hold_7f", 7'h7F, 8,    7'h7F};
    vecs[3] = '{"hold_00", 7'h00, 8,    7'h00};
    vecs[4] = '{"hold_2a", 7'h2A, 8,    7'h2A};
    vecs[5] = '{"hold_33", 7'h33, 3,    7'h33};

    // Reset held low for 5 cycles, checking the asynchronous clear first.
    #12;
    reset = 1'b0;
    #1;
    checkOutput("reset_async_out", 16'(data_out), 16'h0);
    checkOutput("reset_async_ch", 16'(dut.ch_q), 16'h0);
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold_out", 16'(data_out), 16'h0);
      checkOutput("reset_hold_clean", 16'(data_out_clean), 16'h0);
    end
    #2;
    reset = 1'b1;
    modelReset();

    // Held-value vectors; the model checks every cycle, the table the end value.
    for (int v = 0; v < 6; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) applyStimulus(vecs[v].din);
      checkOutput(vecs[v].name, 16'(data_out), 16'(vecs[v].exp_out));
    end

    // Sweep every character, one per clock.
    for (int i = 0; i < 128; i++) applyStimulus(7'(i));

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) applyStimulus(7'($urandom_range(0, 127)));

    // Forced single flip at every position of the all-ones codeword.
    for (int pos = 1; pos <= 11; pos++) begin
      fcw = text_pkg::hamming_enc(7'h7F);
      checkOutput("forced_enc", 16'(fcw), 16'(ref_enc(7'h7F)));
      fcw[pos-1] = ~fcw[pos-1];
      checkOutput("forced_syndrome", 16'(text_pkg::hamming_syndrome(fcw)), 16'(pos));
      checkOutput("forced_extract",
                  16'(text_pkg::hamming_extract(fcw ^ text_pkg::pos_mask(4'(pos)))), 16'h7F);
    end

    // One-cycle reset mid-stream with 0x33 flowing.
    for (int i = 0; i < 6; i++) applyStimulus(7'h33);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_async_out", 16'(data_out), 16'h0);
    checkOutput("midreset_async_clean", 16'(data_out_clean), 16'h0);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("midreset_hold_out", 16'(data_out), 16'h0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(7'h33);
    checkOutput("midreset_recover", 16'(data_out), 16'h33);

    // Every flip position 1..11 should have been exercised by the channel.
    checkOutput("err_pos_coverage", 16'(seen_pos[11:1]), 16'h7FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
